// File: rtl/sub4_serial.sv
// Bit-serial subtractor: one difference bit per clock, LSB first, result committed at the end.
// The final borrow output exists only when SUB_BORROW_OUT_EN is defined.
module sub4_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d
`ifdef SUB_BORROW_OUT_EN
    ,
    output logic             borrow
`endif
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_sh;
    logic [IDX_W-1:0] idx;
    logic             br;
    logic             di;
    logic             br_next;

    // Operands shift right so the bit being processed is always at position 0.
    always_comb begin
        di      = a_sh[0] ^ b_sh[0] ^ br;
        br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            idx     <= '0;
            br      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            d       <= '0;
`ifdef SUB_BORROW_OUT_EN
            borrow  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        idx   <= '0;
                        br    <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    diff_sh <= {di, diff_sh[WIDTH-1:1]};
                    br      <= br_next;
                    idx     <= idx + 1'b1;
                    // Last bit: the full difference is known, publish it in one step.
                    if (idx == LAST_IDX) begin
                        d     <= {di, diff_sh[WIDTH-1:1]};
`ifdef SUB_BORROW_OUT_EN
                        borrow <= br_next;
`endif
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub4_serial.sv
// Self-checking bench for sub4_serial (WIDTH=4): per-cycle compare against a timing/arithmetic
// model plus directed operations with hand-computed results.
module tb_sub4_serial;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
`ifdef SUB_BORROW_OUT_EN
    logic         borrow;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    sub4_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d)
`ifdef SUB_BORROW_OUT_EN
        ,
        .borrow(borrow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: an accepted op occupies W cycles busy, then one cycle done, then one idle cycle.
    bit           m_active;
    int           m_k;
    logic [W-1:0] m_d;
    logic [W-1:0] m_pend_d;
`ifdef SUB_BORROW_OUT_EN
    bit           m_br;
    bit           m_pend_br;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_k      = 0;
            m_d      = '0;
`ifdef SUB_BORROW_OUT_EN
            m_br     = 1'b0;
`endif
        end else begin
            bit was_idle;
            was_idle = !m_active;
            if (m_active) begin
                m_k++;
                if (m_k == W) begin
                    m_d = m_pend_d;
`ifdef SUB_BORROW_OUT_EN
                    m_br = m_pend_br;
`endif
                end
                if (m_k == W + 1) m_active = 1'b0;
            end
            if (was_idle && start) begin
                m_active = 1'b1;
                m_k      = 0;
                m_pend_d = W'((int'(a) - int'(b)) & ((1 << W) - 1));
`ifdef SUB_BORROW_OUT_EN
                m_pend_br = (int'(a) < int'(b));
`endif
            end
        end
    end

    always @(negedge clk) begin
        bit e_busy;
        bit e_done;
        e_busy = m_active && (m_k < W);
        e_done = m_active && (m_k == W);
        n_tests++;
        if (busy !== e_busy || done !== e_done || d !== m_d
`ifdef SUB_BORROW_OUT_EN
            || borrow !== m_br
`endif
            ) begin
            n_fail++;
            $display("FAIL cycle_check t=%0t: busy/done/d got %b/%b/%h want %b/%b/%h",
                     $time, busy, done, d, e_busy, e_done, m_d);
        end
        if (busy === 1'b1 && done === 1'b1) begin
            n_fail++;
            $display("FAIL busy_done_overlap t=%0t: both high", $time);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Called at a negedge with the block idle; returns at the negedge of the idle cycle after
    // DONE so that a following call is back-to-back. poke=1 re-pulses start mid-RUN with new operands.
    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] exp_d, input bit exp_br, input bit poke,
                      input bit lit);
        int lat;
        int busy_cnt;
        bit seen;
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; busy_cnt = (busy === 1'b1) ? 1 : 0; seen = 1'b0;
        for (int i = 2; i <= 20; i++) begin
            @(negedge clk);
            if (poke && i == 3) begin a = '1; b = '0; start = 1'b1; end
            else if (poke && i == 4) start = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin lat = i; seen = 1'b1; break; end
        end
        if (!seen) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout: no done within 20 cycles");
        end else if (lit) begin
            check("latency", 32'(lat), 32'(W + 1));
            check("busy_cycles", 32'(busy_cnt), 32'(W));
            check("result_d", 32'(d), 32'(exp_d));
`ifdef SUB_BORROW_OUT_EN
            check("result_borrow", 32'(borrow), 32'(exp_br));
`else
            if (exp_br) begin end
`endif
        end
        @(negedge clk);
        check("single_done", 32'(done), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_d", 32'(d), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        op(4'b0111, 4'b0010, 4'b0101, 1'b0, 1'b0, 1'b1);
        op(4'b0010, 4'b0111, 4'b1011, 1'b1, 1'b0, 1'b1);
        op(4'b0000, 4'b0001, 4'b1111, 1'b1, 1'b0, 1'b1);
        op(4'b1101, 4'b1101, 4'b0000, 1'b0, 1'b0, 1'b1);
        op(4'b0111, 4'b0010, 4'b0101, 1'b0, 1'b1, 1'b1);

        // Abort mid-RUN with reset; a start held across the reset edge must be ignored.
        a = 4'b1111; b = 4'b0001; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b0; start = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_d", 32'(d), 32'd0);
`ifdef SUB_BORROW_OUT_EN
        check("abort_borrow", 32'(borrow), 32'd0);
`endif
        @(negedge clk);
        start = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 32'(busy), 32'd0);
        op(4'b1011, 4'b0001, 4'b1010, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                op(W'(i), W'(j), W'((i - j) & 15), (i < j), 1'b0, 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
